// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with a valid/ready output, error pulses and a sticky overrun flag.
// Defining UART_RX_PARITY_EN adds a parity bit after the data bits, checked against PARITY_ODD.
module uart_rx_param #(
    parameter int DATA_W     = 8,
    parameter int OVS        = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun
);
    // state    | meaning
    // S_IDLE   | line idle, waiting for a low level
    // S_START  | half a bit into the start bit, confirm it is still low
    // S_DATA   | sample DATA_W bits at bit centres, LSB first
    // S_PARITY | sample and check the parity bit (parity builds only)
    // S_STOP   | sample STOP_BITS stop bits, then report the frame

    localparam int TW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9 || OVS < 8 || OVS > 32 || (OVS % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_rx_param: illegal parameter value");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_sync1;
    logic              r_rxs;
    logic [TW-1:0]     r_tick_cnt;
    logic [TW-1:0]     w_tick_nxt;
    logic [BW-1:0]     r_bit_cnt;
    logic [BW-1:0]     w_bit_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              r_stop_bad;
    logic              w_stop_bad_nxt;
    logic              w_frame_end;
    logic              w_perr;
    logic              w_good;
    logic              w_hs;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= rx_in;
            r_rxs   <= r_sync1;
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic P_ODD = (PARITY_ODD != 0);
    logic r_par_bad;
    logic w_par_bad_nxt;
    assign w_perr = r_par_bad;
`else
    assign w_perr = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_tick_nxt     = r_tick_cnt;
        w_bit_nxt      = r_bit_cnt;
        w_shift_nxt    = r_shift;
        w_stop_bad_nxt = r_stop_bad;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt  = r_par_bad;
`endif
        w_frame_end    = 1'b0;
        if (baud_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rxs) begin
                        w_state_nxt = S_START;
                        w_tick_nxt  = '0;
                    end
                end
                S_START: begin
                    if (r_tick_cnt == TICK_MID) begin
                        // a start bit that has gone high again by mid-bit is treated as noise
                        w_state_nxt    = r_rxs ? S_IDLE : S_DATA;
                        w_tick_nxt     = '0;
                        w_bit_nxt      = '0;
                        w_stop_bad_nxt = 1'b0;
`ifdef UART_RX_PARITY_EN
                        w_par_bad_nxt  = 1'b0;
`endif
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_nxt  = '0;
                        w_shift_nxt = {r_rxs, r_shift[DATA_W-1:1]};
                        if (r_bit_cnt == DATA_LAST) begin
                            w_bit_nxt = '0;
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_nxt    = '0;
                        w_par_bad_nxt = r_rxs ^ (^r_shift) ^ P_ODD;
                        w_state_nxt   = S_STOP;
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_tick_cnt == TICK_END) begin
                        w_tick_nxt     = '0;
                        w_stop_bad_nxt = r_stop_bad | ~r_rxs;
                        if (r_bit_cnt == STOP_LAST) begin
                            w_bit_nxt   = '0;
                            w_state_nxt = S_IDLE;
                            w_frame_end = 1'b1;
                        end else begin
                            w_bit_nxt = r_bit_cnt + 1'b1;
                        end
                    end else begin
                        w_tick_nxt = r_tick_cnt + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_stop_bad <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tick_cnt <= w_tick_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_stop_bad <= w_stop_bad_nxt;
`ifdef UART_RX_PARITY_EN
            r_par_bad  <= w_par_bad_nxt;
`endif
        end
    end

    assign w_hs   = rx_valid & rx_ready;
    assign w_good = w_frame_end & ~w_stop_bad_nxt & ~w_perr;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out  <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_frame_end & w_stop_bad_nxt;
            if (w_good && (!rx_valid || w_hs)) begin
                data_out <= r_shift;
                rx_valid <= 1'b1;
            end else if (w_hs) begin
                rx_valid <= 1'b0;
            end
            // a new word with the holding register still full is dropped
            if (w_good && rx_valid && !w_hs) begin
                overrun <= 1'b1;
            end else if (w_hs) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= w_frame_end & r_par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: a default instance (8N1) and a 9-bit, 2-stop instance driven by bit-level frames.
`timescale 1ns/1ps
module tb_uart_rx_param;
    localparam int OVS  = 16;
    localparam int DW_A = 8;
    localparam int ST_A = 1;
    localparam int DW_B = 9;
    localparam int ST_B = 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif
    localparam bit PODD = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic baud_tick = 1'b0;
    logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b0, rdy_b = 1'b0;
    logic [DW_A-1:0] dout_a;
    logic [DW_B-1:0] dout_b;
    logic v_a, v_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;

    int total = 0;
    int bad = 0;

    // reference model: what each receiver should be holding, plus expected error pulse counts
    logic       m_valid [2];
    logic [8:0] m_data  [2];
    logic       m_ovr   [2];
    int         exp_fe  [2];
    int         exp_pe  [2];
    int         fe_cnt  [2];
    int         pe_cnt  [2];

    uart_rx_param #(.DATA_W(DW_A), .OVS(OVS), .STOP_BITS(ST_A), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_a),
        .data_out(dout_a), .rx_valid(v_a), .rx_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a));

    uart_rx_param #(.DATA_W(DW_B), .OVS(OVS), .STOP_BITS(ST_B), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_b),
        .data_out(dout_b), .rx_valid(v_b), .rx_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b));

    always #5 clk = ~clk;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clk);
            baud_tick = (c == 0);
            c = (c + 1) % 4;
        end
    end

    // counts high cycles, so a stretched pulse shows up as an extra count
    initial begin
        fe_cnt[0] = 0; fe_cnt[1] = 0; pe_cnt[0] = 0; pe_cnt[1] = 0;
        forever begin
            @(negedge clk);
            if (fe_a === 1'b1) fe_cnt[0]++;
            if (fe_b === 1'b1) fe_cnt[1]++;
            if (pe_a === 1'b1) pe_cnt[0]++;
            if (pe_b === 1'b1) pe_cnt[1]++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] od(input bit s);
        return s ? dout_b : {1'b0, dout_a};
    endfunction
    function automatic logic ovld(input bit s);
        return s ? v_b : v_a;
    endfunction
    function automatic logic oovr(input bit s);
        return s ? ov_b : ov_a;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_valid[s] = 1'b0; m_data[s] = '0; m_ovr[s] = 1'b0;
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
    endtask

    task automatic send_bit(input bit s, input logic b);
        @(negedge clk);
        if (s) rx_b = b; else rx_a = b;
        wait_ticks(OVS);
    endtask

    task automatic send_frame(input bit s, input logic [8:0] d, input bit stop_bad, input bit par_bad);
        int   dw = s ? DW_B : DW_A;
        int   ns = s ? ST_B : ST_A;
        logic p  = PODD;
        send_bit(s, 1'b0);
        for (int i = 0; i < dw; i++) begin
            send_bit(s, d[i]);
            p = p ^ d[i];
        end
        if (PEN) send_bit(s, p ^ par_bad);
        for (int k = 0; k < ns; k++) send_bit(s, !(stop_bad && k == ns - 1));
        send_bit(s, 1'b1);
        send_bit(s, 1'b1);
        if (stop_bad) exp_fe[s]++;
        if (PEN && par_bad) exp_pe[s]++;
        if (!stop_bad && !(PEN && par_bad)) begin
            if (!m_valid[s]) begin
                m_data[s]  = d;
                m_valid[s] = 1'b1;
            end else begin
                m_ovr[s] = 1'b1;
            end
        end
    endtask

    task automatic accept(input bit s);
        @(negedge clk);
        if (s) rdy_b = 1'b1; else rdy_a = 1'b1;
        @(negedge clk);
        if (s) rdy_b = 1'b0; else rdy_a = 1'b0;
        if (m_valid[s]) begin
            m_valid[s] = 1'b0;
            m_ovr[s]   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        total++; if (v_a !== 1'b0 || v_b !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b%b expected 00", v_a, v_b); end
        total++; if (dout_a !== 8'h00 || dout_b !== 9'h000) begin bad++; $display("FAIL reset_data: got %h/%h expected 0/0", dout_a, dout_b); end
        total++; if ({fe_a, fe_b, pe_a, pe_b, ov_a, ov_b} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b expected 000000", {fe_a, fe_b, pe_a, pe_b, ov_a, ov_b}); end
        rst = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_basic();
        send_frame(1'b0, 9'h0A5, 1'b0, 1'b0);
        total++; if (v_a !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b expected 1", v_a); end
        total++; if (od(1'b0) !== 9'h0A5) begin bad++; $display("FAIL basic_data: got %h expected 0a5", od(1'b0)); end
        total++; if (fe_cnt[0] != exp_fe[0] || pe_cnt[0] != exp_pe[0]) begin bad++; $display("FAIL basic_err: got fe=%0d pe=%0d expected 0 0", fe_cnt[0], pe_cnt[0]); end
        total++; if (ov_a !== 1'b0) begin bad++; $display("FAIL basic_ovr: got %b expected 0", ov_a); end
        accept(1'b0);
        total++; if (v_a !== 1'b0) begin bad++; $display("FAIL basic_accept: got %b expected 0", v_a); end
        total++; if (od(1'b0) !== 9'h0A5) begin bad++; $display("FAIL basic_hold: got %h expected 0a5", od(1'b0)); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        rx_a = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx_a = 1'b1;
        wait_ticks(2 * OVS);
        total++; if (v_a !== 1'b0) begin bad++; $display("FAIL glitch_valid: got %b expected 0", v_a); end
        total++; if (fe_cnt[0] != exp_fe[0] || pe_cnt[0] != exp_pe[0]) begin bad++; $display("FAIL glitch_err: got fe=%0d pe=%0d expected %0d %0d", fe_cnt[0], pe_cnt[0], exp_fe[0], exp_pe[0]); end
        send_frame(1'b0, 9'h05A, 1'b0, 1'b0);
        total++; if (v_a !== 1'b1 || od(1'b0) !== 9'h05A) begin bad++; $display("FAIL glitch_next: got v=%b d=%h expected v=1 d=05a", v_a, od(1'b0)); end
        accept(1'b0);
    endtask

    task automatic test_frame_err();
        send_frame(1'b0, 9'h03C, 1'b1, 1'b0);
        total++; if (fe_cnt[0] != exp_fe[0]) begin bad++; $display("FAIL ferr_pulse: got %0d cycles expected %0d", fe_cnt[0], exp_fe[0]); end
        total++; if (v_a !== 1'b0) begin bad++; $display("FAIL ferr_valid: got %b expected 0", v_a); end
        total++; if (od(1'b0) !== m_data[0]) begin bad++; $display("FAIL ferr_data: got %h expected %h", od(1'b0), m_data[0]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(1'b0, 9'h007, 1'b0, 1'b1);
        total++; if (pe_cnt[0] != exp_pe[0]) begin bad++; $display("FAIL perr_pulse: got %0d cycles expected %0d", pe_cnt[0], exp_pe[0]); end
        total++; if (v_a !== 1'b0) begin bad++; $display("FAIL perr_valid: got %b expected 0", v_a); end
        send_frame(1'b0, 9'h007, 1'b0, 1'b0);
        total++; if (v_a !== 1'b1 || od(1'b0) !== 9'h007) begin bad++; $display("FAIL perr_good: got v=%b d=%h expected v=1 d=007", v_a, od(1'b0)); end
        accept(1'b0);
    endtask
`endif

    task automatic test_overrun();
        send_frame(1'b0, 9'h011, 1'b0, 1'b0);
        send_frame(1'b0, 9'h022, 1'b0, 1'b0);
        total++; if (od(1'b0) !== 9'h011) begin bad++; $display("FAIL ovr_data: got %h expected 011", od(1'b0)); end
        total++; if (v_a !== 1'b1 || ov_a !== 1'b1) begin bad++; $display("FAIL ovr_flags: got v=%b o=%b expected v=1 o=1", v_a, ov_a); end
        accept(1'b0);
        total++; if (v_a !== 1'b0 || ov_a !== 1'b0) begin bad++; $display("FAIL ovr_clear: got v=%b o=%b expected v=0 o=0", v_a, ov_a); end
    endtask

    task automatic test_reset_mid();
        logic [8:0] junk = 9'h0A6;
        send_bit(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, junk[i]);
        @(negedge clk);
        rx_b = 1'b1;
        rst  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        wait_ticks(3 * OVS);
        total++; if (v_b !== 1'b0 || od(1'b1) !== 9'h000) begin bad++; $display("FAIL rstmid_out: got v=%b d=%h expected v=0 d=000", v_b, od(1'b1)); end
        total++; if (fe_cnt[1] != exp_fe[1] || pe_cnt[1] != exp_pe[1]) begin bad++; $display("FAIL rstmid_err: got fe=%0d pe=%0d expected %0d %0d", fe_cnt[1], pe_cnt[1], exp_fe[1], exp_pe[1]); end
        send_frame(1'b1, 9'h1FF, 1'b0, 1'b0);
        total++; if (v_b !== 1'b1 || od(1'b1) !== 9'h1FF) begin bad++; $display("FAIL rstmid_frame: got v=%b d=%h expected v=1 d=1ff", v_b, od(1'b1)); end
        accept(1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            bit         s  = 1'($urandom_range(0, 1));
            logic [8:0] d  = s ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 255));
            bit         sb = ($urandom_range(0, 4) == 0);
            bit         pb = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 1) == 1) accept(s);
            send_frame(s, d, sb, pb);
            total++; if (ovld(s) !== m_valid[s]) begin bad++; $display("FAIL rand_valid[%0d]: got %b expected %b", n, ovld(s), m_valid[s]); end
            total++; if (od(s) !== m_data[s]) begin bad++; $display("FAIL rand_data[%0d]: got %h expected %h", n, od(s), m_data[s]); end
            total++; if (oovr(s) !== m_ovr[s]) begin bad++; $display("FAIL rand_ovr[%0d]: got %b expected %b", n, oovr(s), m_ovr[s]); end
            total++; if (fe_cnt[s] != exp_fe[s] || pe_cnt[s] != exp_pe[s]) begin bad++; $display("FAIL rand_err[%0d]: got fe=%0d pe=%0d expected %0d %0d", n, fe_cnt[s], pe_cnt[s], exp_fe[s], exp_pe[s]); end
        end
    endtask

    initial begin
        exp_fe[0] = 0; exp_fe[1] = 0; exp_pe[0] = 0; exp_pe[1] = 0;
        model_reset();
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_overrun();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
